result_tx_sequencer: RTL

- Serializes ALU results into bytes for the UART transmitter and reports transmit occupancy as UART_Busy to the FSM controller, which gates further ALU operations on it.
- Sits between the ALU result port and the UART TX parallel-load interface; it is the consuming end of the ALU-enable / UART_Busy handshake.
- Sends one byte for compare-class functions and two bytes (LSB first) for all other functions.

---
 rtl/system_pkg.sv | 29 ++
 rtl/tx_byte_handshake.sv | 61 ++++++
 rtl/result_tx_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/system_pkg.sv
// Shared types and constants for the ALU-result-to-UART transmit path.
package system_pkg;

    localparam int unsigned BYTE_WIDTH = 8;

    // ALU_FUN[3:2] value that marks a compare-class result (one byte only).
    localparam logic [1:0] FUN_CMP_CLASS = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        WAIT_START_LO,
        WAIT_END_LO,
        LOAD_HI,
        WAIT_START_HI,
        WAIT_END_HI
    } seq_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WAIT_START,
        HS_WAIT_END
    } hs_state_t;

    function automatic logic is_one_byte(input logic [3:0] fun);
        return fun[3:2] == FUN_CMP_CLASS;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// Single-byte load/start/end handshake with the UART transmitter.
module tx_byte_handshake
    import system_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_byte,
    input  logic             tx_busy,
    output logic             byte_done_c,
    output logic             tx_d_vld,
    output logic [WIDTH-1:0] tx_p_data
);

    hs_state_t        state_q;
    hs_state_t        state_d;
    logic             vld_d;
    logic [WIDTH-1:0] data_d;

    // Strobe only when the transmitter is idle; then wait for its frame to rise and fall.
    always_comb begin
        state_d     = state_q;
        vld_d       = 1'b0;
        data_d      = tx_p_data;
        byte_done_c = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (start && !tx_busy) begin
                    vld_d   = 1'b1;
                    data_d  = tx_byte;
                    state_d = HS_WAIT_START;
                end
            end
            HS_WAIT_START: begin
                if (tx_busy) state_d = HS_WAIT_END;
            end
            HS_WAIT_END: begin
                if (!tx_busy) begin
                    byte_done_c = 1'b1;
                    state_d     = HS_IDLE;
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HS_IDLE;
            tx_d_vld  <= 1'b0;
            tx_p_data <= '0;
        end else begin
            state_q   <= state_d;
            tx_d_vld  <= vld_d;
            tx_p_data <= data_d;
        end
    end

endmodule

// File: rtl/result_tx_sequencer.sv
// Splits an ALU result into one or two UART bytes (LSB first) and reports occupancy.
module result_tx_sequencer
    import system_pkg::*;
#(
    parameter int unsigned RESULT_WIDTH = 16,
    parameter int unsigned BYTE_WIDTH   = system_pkg::BYTE_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RESULT_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_VALID,
    input  logic [3:0]              ALU_FUN,
    input  logic                    TX_Busy,
    output logic [BYTE_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    UART_Busy,
    output logic                    Overrun
);

    seq_state_t              state_q;
    seq_state_t              state_d;
    logic [RESULT_WIDTH-1:0] result_q;
    logic [RESULT_WIDTH-1:0] result_d;
    logic                    one_byte_q;
    logic                    one_byte_d;
    logic                    busy_d;
    logic                    overrun_d;
    logic                    hs_start_c;
    logic                    hs_done_c;
    logic [BYTE_WIDTH-1:0]   hs_byte_c;

    assign hs_start_c = (state_q == LOAD_LO) || (state_q == LOAD_HI);
    assign hs_byte_c  = (state_q == LOAD_HI) ? result_q[RESULT_WIDTH-1 -: BYTE_WIDTH]
                                             : result_q[BYTE_WIDTH-1:0];

    // UART_Busy is high exactly outside IDLE, so a result arriving while it is set is dropped.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        one_byte_d = one_byte_q;
        busy_d     = UART_Busy;
        overrun_d  = OUT_VALID && UART_Busy;
        case (state_q)
            IDLE: begin
                if (OUT_VALID) begin
                    result_d   = ALU_OUT;
                    one_byte_d = is_one_byte(ALU_FUN);
                    busy_d     = 1'b1;
                    state_d    = LOAD_LO;
                end
            end
            LOAD_LO:       if (!TX_Busy) state_d = WAIT_START_LO;
            WAIT_START_LO: if (TX_Busy)  state_d = WAIT_END_LO;
            WAIT_END_LO: begin
                if (hs_done_c) begin
                    if (one_byte_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end
            end
            LOAD_HI:       if (!TX_Busy) state_d = WAIT_START_HI;
            WAIT_START_HI: if (TX_Busy)  state_d = WAIT_END_HI;
            WAIT_END_HI: begin
                if (hs_done_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            result_q   <= '0;
            one_byte_q <= 1'b0;
            UART_Busy  <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            one_byte_q <= one_byte_d;
            UART_Busy  <= busy_d;
            Overrun    <= overrun_d;
        end
    end

    tx_byte_handshake #(
        .WIDTH(BYTE_WIDTH)
    ) u_handshake (
        .clk        (CLK),
        .rst_n      (RST),
        .start      (hs_start_c),
        .tx_byte    (hs_byte_c),
        .tx_busy    (TX_Busy),
        .byte_done_c(hs_done_c),
        .tx_d_vld   (TX_D_VLD),
        .tx_p_data  (TX_P_DATA)
    );

endmodule
